// File: rtl/param_reg_file.sv
// Small register file with registered read port and a sequential clear engine.
// Optional sticky write-while-busy flag enabled by defining PARAM_REG_FILE_WR_ERR_EN.
module param_reg_file #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  d,
  input  logic              rd,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clr,
  output logic [WIDTH-1:0]  q,
  output logic              q_valid,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  q_q;
  logic              q_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      unique case (state_q)
        StIdle: begin
          q_valid_q <= rd;
          if (rd) begin
            // Write-first bypass; a write colliding with clr is dropped, so no bypass then.
            q_q <= (wr && !clr && (waddr == raddr)) ? d : mem_q[raddr];
          end
          if (clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
          end else if (wr) begin
            mem_q[waddr] <= d;
          end
        end
        StClear: begin
          q_valid_q    <= 1'b0;
          mem_q[ptr_q] <= '0;
          ptr_q        <= ptr_q + 1'b1;
          if (ptr_q == LastPtr) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == StClear);

`ifdef PARAM_REG_FILE_WR_ERR_EN
  logic wr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else if (wr && busy) begin
      wr_err_q <= 1'b1;
    end
  end

  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_param_reg_file;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, wr, rd, clr;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              q_valid, busy, wr_err;

  param_reg_file #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .waddr   (waddr),
    .d       (d),
    .rd      (rd),
    .raddr   (raddr),
    .clr     (clr),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  // Reference model: storage array plus "cycles of clearing still to go".
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               clear_left;
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  logic             m_err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PARAM_REG_FILE_WR_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      clear_left = 0;
      m_q        = '0;
      m_qv       = 1'b0;
      m_err      = 1'b0;
    end else if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = '0;
      clear_left--;
      m_qv = 1'b0;
      if (wr && ErrEn) m_err = 1'b1;
    end else begin
      m_qv = rd;
      if (rd) m_q = (wr && !clr && waddr == raddr) ? d : m_mem[raddr];
      if (clr) clear_left = DEPTH;
      else if (wr) m_mem[waddr] = d;
    end
  endtask

  task automatic drive_cycle(input logic r, input logic w, input logic c, input logic rdd,
                             input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                             input logic [WIDTH-1:0] dd);
    rst = r; wr = w; clr = c; rd = rdd; waddr = wa; raddr = ra; d = dd;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("q", 32'(q), 32'(m_q));
    check_eq("q_valid", 32'(q_valid), 32'(m_qv));
    check_eq("busy", 32'(busy), 32'(clear_left != 0));
    check_eq("wr_err", 32'(wr_err), 32'(m_err));
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] v);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, a, '0, v);
  endtask

  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [WIDTH-1:0] v);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, a, '0);
    check_eq(tag, 32'(q), 32'(v));
  endtask

  int busy_cnt;

  initial begin
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 8'hEE);
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    // Basic write then read with one-cycle latency
    write(2'd0, 8'hA5);
    write(2'd3, 8'h3C);
    read_expect("rd3_q", 2'd3, 8'h3C);
    check_eq("rd3_qv", 32'(q_valid), 32'h1);
    idle();
    check_eq("rd3_qv_pulse", 32'(q_valid), 32'h0);
    read_expect("rd0_q", 2'd0, 8'hA5);

    // Write-first bypass
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 8'h77);
    check_eq("bypass_q", 32'(q), 32'h77);
    idle();
    read_expect("bypass_later", 2'd1, 8'h77);

    // Clear: busy for exactly DEPTH cycles, all entries zero afterwards
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), 8'hFF);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    busy_cnt = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      busy_cnt++;
      idle();
    end
    check_eq("busy_len", 32'(busy_cnt), 32'd4);
    for (int i = 0; i < DEPTH; i++) read_expect("clr_zero", ADDR_W'(i), 8'h00);

    // Lockout: writes and reads during clear are ignored
    write(2'd2, 8'h99);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 8'h11);
      check_eq("lock_qv", 32'(q_valid), 32'h0);
    end
    check_eq("lock_busy_done", 32'(busy), 32'h0);
    check_eq("lock_err", 32'(wr_err), 32'(ErrEn));
    read_expect("lock_e2", 2'd2, 8'h00);

    // Reset in the second clear cycle
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), WIDTH'(8'h40 + i));
    read_expect("pre_rst_rd", 2'd1, 8'h41);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    idle();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 8'h22);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_q", 32'(q), 32'h0);
    check_eq("mid_rst_qv", 32'(q_valid), 32'h0);
    check_eq("mid_rst_err", 32'(wr_err), 32'h0);
    for (int i = 0; i < DEPTH; i++) read_expect("mid_rst_zero", ADDR_W'(i), 8'h00);

    // clr + wr collision: write dropped
    write(2'd1, 8'h12);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, '0, 8'h5A);
    for (int i = 0; i < DEPTH; i++) idle();
    read_expect("coll_e0", 2'd0, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 1) == 1),
                  ADDR_W'($urandom), ADDR_W'($urandom), WIDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 2, the address width; DEPTH = 2**ADDR_W entries.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr  input  1  write request for the current cycle.
REQ-006 waddr  input  ADDR_W  write address.
REQ-007 d  input  WIDTH  write data.
REQ-008 rd  input  1  read request for the current cycle.
REQ-009 raddr  input  ADDR_W  read address.
REQ-010 clr  input  1  start a sequential clear of all entries.
REQ-011 q  output  WIDTH  registered read data.
REQ-012 q_valid  output  1  one-cycle pulse qualifying q.
REQ-013 busy  output  1  high while a clear sequence runs.
REQ-014 wr_err  output  1  sticky flag for a write attempted while busy (see Configuration).

Function
REQ-015 The block SHALL implement two FSM states: IDLE and CLEAR; busy SHALL be 1 exactly in CLEAR.
REQ-016 In IDLE, wr=1 with clr=0 SHALL write d into entry waddr at the clock edge.
REQ-017 In IDLE, clr=1 SHALL move the FSM to CLEAR with clear pointer 0; a wr in that same cycle SHALL be dropped.
REQ-018 In CLEAR, the block SHALL zero the entry at the pointer each cycle and increment the pointer. After zeroing entry DEPTH-1, it SHALL return to IDLE, giving busy high for exactly DEPTH cycles.
REQ-019 In CLEAR, wr and clr SHALL be ignored, and the pointer SHALL NOT restart.
REQ-020 A read with rd=1 in IDLE SHALL load q with entry raddr and assert q_valid for one cycle, one edge later (latency 1).
REQ-021 If rd and wr target the same address in the same IDLE cycle, q SHALL return the new data d (write-first bypass).
REQ-022 In CLEAR, rd SHALL be ignored: q_valid stays 0 and q holds its value.
REQ-023 When no read is accepted, q SHALL hold its last value and q_valid SHALL be 0.
REQ-024 Addresses SHALL always be in range; no wrap or out-of-range handling is required.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear pointer 0, q=0, q_valid=0, busy=0 and wr_err=0.
REQ-026 Reset SHALL zero every storage entry, including when asserted in the middle of a CLEAR sequence.
REQ-027 rst SHALL take priority over wr, rd and clr in the same cycle.

Configuration
REQ-028 With macro PARAM_REG_FILE_WR_ERR_EN defined, wr_err SHALL set to 1 on any cycle with wr=1 while busy=1, and SHALL stay set until rst.
REQ-029 Without PARAM_REG_FILE_WR_ERR_EN, wr_err SHALL be tied to 0 and no error logic SHALL be built; all other behaviour is identical.

Verification
REQ-030 Write/read: WIDTH=8, ADDR_W=2; write 8'hA5@0, 8'h3C@3, then rd raddr=3 -> next cycle q=8'h3C, q_valid=1 for one cycle.
REQ-031 Bypass: wr=1, rd=1, waddr=raddr=1, d=8'h77 in one cycle -> next cycle q=8'h77; a later read of 1 also returns 8'h77.
REQ-032 Clear: fill all 4 entries with 8'hFF, pulse clr -> busy high exactly 4 cycles; afterwards reads of 0..3 all return 8'h00.
REQ-033 Busy lockout: during CLEAR drive wr=1 d=8'h11 waddr=2 and rd=1 -> no q_valid; entry 2 reads 8'h00 after the clear; wr_err=1 with the macro, 0 without.
REQ-034 Reset mid-clear: assert rst in the 2nd CLEAR cycle -> next cycle busy=0, q=0, q_valid=0, wr_err=0, all entries 0.
REQ-035 clr+wr collision in IDLE: clr=1, wr=1 waddr=0 d=8'h5A -> write dropped; entry 0 reads 8'h00 after the clear.
